// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter: shares one 64-bit left barrel shifter between two
// round-robin requesters. The block derives SLL, SRL, SRA and ROL from that
// shifter by bit-reversing the operand and, where needed, making a second pass.

// Logarithmic 64-bit left shifter, zero fill, 6-bit shift amount.
module barrel_shifter_left (
    input  logic [63:0] din,
    input  logic [5:0]  shamt,
    output logic [63:0] dout
);

    logic [6:0][63:0] stage;

    // Each stage shifts by 2^i when bit i of the amount is set.
    always_comb begin
        stage[0] = din;
        for (int unsigned i = 0; i < 6; i++) begin
            stage[i + 1] = shamt[i] ? (stage[i] << (1 << i)) : stage[i];
        end
    end

    assign dout = stage[6];

endmodule

module shift_unit_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_data,
    input  logic [5:0]  req0_shamt,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_data,
    input  logic [5:0]  req1_shamt,
    input  logic [1:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_id
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS1 = 2'd1,
        S_PASS2 = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_t;

    function automatic logic [63:0] bit_rev(input logic [63:0] x);
        logic [63:0] r;
        for (int unsigned i = 0; i < 64; i++) begin
            r[i] = x[63 - i];
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [63:0] data_q, data_d;
    logic [5:0]  shamt_q, shamt_d;
    op_t         op_q, op_d;
    logic        id_q, id_d;
    logic [63:0] p1_q, p1_d;
    logic        last_grant_q, last_grant_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic        rsp_id_q, rsp_id_d;

    logic        grant_id;
    logic        accept;
    logic [63:0] sh_in;
    logic [5:0]  sh_amt;
    logic [63:0] sh_out;
    logic [63:0] sh_rev;

    // Round-robin grant: a lone requester wins, a tie goes away from last_grant.
    always_comb begin
        grant_id   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req1_valid;
        end
        if (state_q == S_IDLE) begin
            req0_ready = req0_valid & ~grant_id;
            req1_ready = req1_valid &  grant_id;
        end
    end

    assign accept = req0_ready | req1_ready;

    // Shifter operand selection. Right shifts are left shifts of the reversed
    // word; SRA's sign fill and ROL's wrapped half come from a second pass.
    always_comb begin
        sh_in  = data_q;
        sh_amt = shamt_q;
        case (state_q)
            S_PASS1: begin
                if (op_q == OP_SRL || op_q == OP_SRA) begin
                    sh_in = bit_rev(data_q);
                end
            end
            S_PASS2: begin
                if (op_q == OP_SRA) begin
                    sh_in = '1;
                end else begin
                    sh_in  = bit_rev(data_q);
                    sh_amt = 6'd0 - shamt_q;
                end
            end
            default: begin
                sh_in  = data_q;
                sh_amt = shamt_q;
            end
        endcase
    end

    barrel_shifter_left u_shifter (
        .din   (sh_in),
        .shamt (sh_amt),
        .dout  (sh_out)
    );

    assign sh_rev = bit_rev(sh_out);

    // Next-state and register-update logic for the sequencing FSM.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        shamt_d      = shamt_q;
        op_d         = op_q;
        id_d         = id_q;
        p1_d         = p1_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_d       = grant_id ? req1_data  : req0_data;
                    shamt_d      = grant_id ? req1_shamt : req0_shamt;
                    op_d         = op_t'(grant_id ? req1_op : req0_op);
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    state_d      = S_PASS1;
                end
            end
            S_PASS1: begin
                case (op_q)
                    OP_SLL: begin
                        rsp_data_d  = sh_out;
                        rsp_id_d    = id_q;
                        rsp_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
                    OP_SRL: begin
                        rsp_data_d  = sh_rev;
                        rsp_id_d    = id_q;
                        rsp_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
                    OP_SRA: begin
                        p1_d    = sh_rev;
                        state_d = S_PASS2;
                    end
                    OP_ROL: begin
                        p1_d    = sh_out;
                        state_d = S_PASS2;
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
            S_PASS2: begin
                if (op_q == OP_SRA) begin
                    rsp_data_d = p1_q | (data_q[63] ? ~sh_rev : '0);
                end else begin
                    rsp_data_d = p1_q | sh_rev;
                end
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; last_grant resets to 1 so req0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            data_q       <= '0;
            shamt_q      <= '0;
            op_q         <= OP_SLL;
            id_q         <= 1'b0;
            p1_q         <= '0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            shamt_q      <= shamt_d;
            op_q         <= op_d;
            id_q         <= id_d;
            p1_q         <= p1_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Bench for shift_unit_arbiter: a transaction-level reference model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_shift_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [63:0] req0_data, req1_data;
    logic [5:0]  req0_shamt, req1_shamt;
    logic [1:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_id;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_unit_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_shamt (req0_shamt),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_shamt (req1_shamt),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result from plain operator semantics.
    function automatic logic [63:0] ref_op(input logic [63:0] d, input logic [5:0] s,
                                           input logic [1:0] op);
        logic [6:0] inv;
        inv = 7'd64 - {1'b0, s};
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return $signed(d) >>> s;
            default: return (d << s) | (d >> inv);
        endcase
    endfunction

    // Transaction model: who is idle, who should be granted, and when the result appears.
    bit          m_busy  = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_id    = 1'b0;
    bit          m_rid   = 1'b0;
    bit          m_last  = 1'b1;
    logic [63:0] m_data  = '0;
    logic [63:0] m_res   = '0;
    int          m_cnt   = 0;

    always @(negedge clk) begin : model
        bit e_r0, e_r1;
        if (rst) begin
            m_busy = 1'b0; m_valid = 1'b0; m_id = 1'b0; m_last = 1'b1;
            m_data = '0; m_cnt = 0;
            chk("model_rst_valid", {63'd0, rsp_valid}, 64'd0);
            chk("model_rst_data", rsp_data, 64'd0);
        end else begin
            e_r0 = 1'b0;
            e_r1 = 1'b0;
            if (!m_busy) begin
                if (req0_valid && (!req1_valid || m_last)) e_r0 = 1'b1;
                else if (req1_valid) e_r1 = 1'b1;
            end
            chk("model_req0_ready", {63'd0, req0_ready}, {63'd0, e_r0});
            chk("model_req1_ready", {63'd0, req1_ready}, {63'd0, e_r1});
            chk("model_rsp_valid", {63'd0, rsp_valid}, {63'd0, m_valid});
            chk("model_rsp_data", rsp_data, m_data);
            chk("model_rsp_id", {63'd0, rsp_id}, {63'd0, m_id});
            if (m_valid) begin
                if (rsp_ready) begin
                    m_valid = 1'b0;
                    m_busy  = 1'b0;
                end
            end else if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_valid = 1'b1;
                    m_data  = m_res;
                    m_id    = m_rid;
                end
            end else if (e_r0 || e_r1) begin
                m_busy = 1'b1;
                m_rid  = e_r1;
                m_last = e_r1;
                if (e_r1) begin
                    m_res = ref_op(req1_data, req1_shamt, req1_op);
                    m_cnt = req1_op[1] ? 2 : 1;
                end else begin
                    m_res = ref_op(req0_data, req0_shamt, req0_op);
                    m_cnt = req0_op[1] ? 2 : 1;
                end
            end
        end
    end

    task automatic set_req(input bit id, input logic [63:0] d, input logic [5:0] s,
                           input logic [1:0] op);
        if (id) begin
            req1_valid = 1'b1; req1_data = d; req1_shamt = s; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_data = d; req0_shamt = s; req0_op = op;
        end
    endtask

    // Waits (bounded) for a request handshake on requester id; returns its cycle.
    task automatic wait_hs(input bit id, output int unsigned c);
        bit ok;
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (id ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) begin
                ok = 1'b1;
                c  = cyc;
                break;
            end
        end
        if (!ok) chk("hs_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input string name, input bit id, input logic [63:0] d,
                          input logic [5:0] s, input logic [1:0] op,
                          input logic [63:0] exp, input int unsigned exp_lat);
        int unsigned c_hs;
        bit got;
        set_req(id, d, s, op);
        wait_hs(id, c_hs);
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk({name, "_rsp_timeout"}, 64'd0, 64'd1);
        chk({name, "_data"}, rsp_data, exp);
        chk({name, "_id"}, {63'd0, rsp_id}, {63'd0, id});
        chk({name, "_latency"}, 64'(cyc - c_hs), 64'(exp_lat));
        @(negedge clk);
        chk({name, "_one_cycle"}, {63'd0, rsp_valid}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int unsigned c_hs;
        int unsigned c_rsp;
        int unsigned n_hs;
        bit ids[4];
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        req0_shamt = '0; req1_shamt = '0;
        req0_op = '0; req1_op = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_rsp_data", rsp_data, 64'd0);
        chk("reset_rsp_id", {63'd0, rsp_id}, 64'd0);
        rst = 1'b0;

        run_op("sll13",   1'b0, 64'h1, 6'd13, 2'b00, 64'h0000_0000_0000_2000, 2);
        run_op("srl4",    1'b0, 64'h8000_0000_0000_0000, 6'd4, 2'b01, 64'h0800_0000_0000_0000, 2);
        run_op("sra4",    1'b1, 64'h8000_0000_0000_0000, 6'd4, 2'b10, 64'hF800_0000_0000_0000, 3);
        run_op("srl63",   1'b0, 64'h8000_0000_0000_0000, 6'd63, 2'b01, 64'h1, 2);
        run_op("sra63",   1'b1, 64'h8000_0000_0000_0000, 6'd63, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 3);
        run_op("srl0",    1'b0, 64'h8000_0000_0000_1234, 6'd0, 2'b01, 64'h8000_0000_0000_1234, 2);
        run_op("sra0",    1'b1, 64'h8000_0000_0000_1234, 6'd0, 2'b10, 64'h8000_0000_0000_1234, 3);
        run_op("rol4",    1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 6'd4, 2'b11, 64'h0F0F_0F0F_0F0F_0F0F, 3);
        run_op("rol0",    1'b1, 64'hDEAD_BEEF_0123_4567, 6'd0, 2'b11, 64'hDEAD_BEEF_0123_4567, 3);
        run_op("rol1",    1'b0, 64'h8000_0000_0000_0001, 6'd1, 2'b11, 64'h0000_0000_0000_0003, 3);
        run_op("sra_pos", 1'b1, 64'h4000_0000_0000_0000, 6'd2, 2'b10, 64'h1000_0000_0000_0000, 3);

        // Tie arbitration after reset: req0, req1, req0, req1.
        pulse_reset();
        set_req(1'b0, 64'h1111, 6'd1, 2'b00);
        set_req(1'b1, 64'h2222, 6'd1, 2'b00);
        n_hs = 0;
        for (int i = 0; i < 40 && n_hs < 4; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) begin ids[n_hs] = 1'b0; n_hs++; end
            else if (req1_valid && req1_ready) begin ids[n_hs] = 1'b1; n_hs++; end
        end
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        chk("arb_count", 64'(n_hs), 64'd4);
        chk("arb_seq0", {63'd0, ids[0]}, 64'd0);
        chk("arb_seq1", {63'd0, ids[1]}, 64'd1);
        chk("arb_seq2", {63'd0, ids[2]}, 64'd0);
        chk("arb_seq3", {63'd0, ids[3]}, 64'd1);
        repeat (5) @(posedge clk);
        #1;

        // Backpressure: hold the response for 5 cycles with req1 pending.
        rsp_ready = 1'b0;
        set_req(1'b0, 64'h5, 6'd2, 2'b00);
        wait_hs(1'b0, c_hs);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        set_req(1'b1, 64'h3, 6'd3, 2'b01);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_data", rsp_data, 64'h14);
            chk("bp_id", {63'd0, rsp_id}, 64'd0);
            chk("bp_ready0", {63'd0, req0_ready}, 64'd0);
            chk("bp_ready1", {63'd0, req1_ready}, 64'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        c_rsp = cyc;
        chk("bp_release_valid", {63'd0, rsp_valid}, 64'd1);
        wait_hs(1'b1, c_hs);
        chk("bp_next_accept", 64'(c_hs - c_rsp), 64'd1);
        @(posedge clk);
        #1 req1_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Reset during PASS2 of an SRA.
        set_req(1'b0, 64'h8000_0000_0000_0000, 6'd4, 2'b10);
        wait_hs(1'b0, c_hs);
        @(posedge clk);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_async_data", rsp_data, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        @(posedge clk);
        #1;
        set_req(1'b0, 64'h7, 6'd0, 2'b00);
        set_req(1'b1, 64'h9, 6'd0, 2'b00);
        @(negedge clk);
        chk("rst_tie_ready0", {63'd0, req0_ready}, 64'd1);
        chk("rst_tie_ready1", {63'd0, req1_ready}, 64'd0);
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
